// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with parametrised exponent and mantissa widths.
// One shift per cycle: align the smaller operand, add, normalize, then truncate and pack.
module fp_addsub_seq #(
  parameter int EW = 6,
  parameter int MW = 25,
  localparam int W = 1 + EW + MW
) (
  input  logic         clock_100kHz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_A_in,
  input  logic [W-1:0] op_B_in,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic [3:0]   status_out,
  output logic [2:0]   qual_lugar
);

  // Working mantissa frame: hidden bit, MW stored bits, guard/round/sticky.
  localparam int FW = MW + 4;
  localparam int SW = FW + 1;
  localparam int XW = EW + $clog2(FW) + 2;
  localparam int CW = $clog2(FW);

  localparam logic signed [XW-1:0] EXP_MAX   = XW'((2 ** EW) - 1);
  localparam logic        [XW-1:0] SHIFT_CAP = XW'(FW - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] PACK  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]           state;
  logic [FW-1:0]        big_m, small_m;
  logic                 big_s, small_s, res_s;
  logic signed [XW-1:0] exp_r;
  logic [CW-1:0]        cnt;
  logic [SW-1:0]        sum;

  // Operand unpack, evaluated on the live inputs for the acceptance edge.
  logic          a_zero, b_zero, b_sign, a_big;
  logic [XW-1:0] ea, eb, ea_eff, eb_eff, diff;
  logic [FW-1:0] ma, mb;
  logic [CW-1:0] d;

  always_comb begin
    a_zero = ~|op_A_in[W-2:MW];
    b_zero = ~|op_B_in[W-2:MW];
    b_sign = op_B_in[W-1] ^ op_sub;
    ea     = XW'(op_A_in[W-2:MW]);
    eb     = XW'(op_B_in[W-2:MW]);
    ma     = a_zero ? '0 : {1'b1, op_A_in[MW-1:0], 3'b000};
    mb     = b_zero ? '0 : {1'b1, op_B_in[MW-1:0], 3'b000};
    // A zero operand borrows the other exponent so it never forces an alignment.
    ea_eff = a_zero ? eb : ea;
    eb_eff = b_zero ? ea : eb;
    a_big  = ea_eff >= eb_eff;
    diff   = a_big ? ea_eff - eb_eff : eb_eff - ea_eff;
    d      = (diff > SHIFT_CAP) ? CW'(FW - 1) : diff[CW-1:0];
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign qual_lugar = state;

  // NOTE: all state here is sequential, so every assignment below is non-blocking;
  // mixing in blocking assignments would make results depend on evaluation order.
  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      big_m      <= '0;
      small_m    <= '0;
      big_s      <= 1'b0;
      small_s    <= 1'b0;
      res_s      <= 1'b0;
      exp_r      <= '0;
      cnt        <= '0;
      sum        <= '0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          big_m   <= a_big ? ma : mb;
          small_m <= a_big ? mb : ma;
          big_s   <= a_big ? op_A_in[W-1] : b_sign;
          small_s <= a_big ? b_sign : op_A_in[W-1];
          exp_r   <= $signed(a_big ? ea_eff : eb_eff);
          cnt     <= d;
          state   <= (d != '0) ? ALIGN : ADD;
        end
        ALIGN: begin
          small_m <= {1'b0, small_m[FW-1:2], small_m[1] | small_m[0]};
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= ADD;
        end
        ADD: begin
          if (big_s == small_s) begin
            sum   <= SW'(big_m) + SW'(small_m);
            res_s <= big_s;
          end else if (big_m >= small_m) begin
            sum   <= SW'(big_m) - SW'(small_m);
            res_s <= (big_m == small_m) ? 1'b0 : big_s;
          end else begin
            sum   <= SW'(small_m) - SW'(big_m);
            res_s <= small_s;
          end
          state <= NORM;
        end
        NORM: begin
          if (sum[SW-1]) begin
            sum   <= {1'b0, sum[SW-1:2], sum[1] | sum[0]};
            exp_r <= exp_r + 1'b1;
            state <= PACK;
          end else if (sum[FW-1] || sum == '0) begin
            state <= PACK;
          end else begin
            // Leave once the bit just below the hidden position is about to move up.
            sum   <= sum << 1;
            exp_r <= exp_r - 1'b1;
            if (sum[FW-2]) state <= PACK;
          end
        end
        PACK: begin
          if (sum == '0) begin
            data_out   <= '0;
            status_out <= 4'b0001;
          end else if (exp_r > EXP_MAX) begin
            data_out   <= {res_s, {EW{1'b1}}, {MW{1'b1}}};
            status_out <= 4'b1010;
          end else if (exp_r < $signed(XW'(1))) begin
            data_out   <= '0;
            status_out <= 4'b0101;
          end else begin
            data_out   <= {res_s, exp_r[EW-1:0], sum[FW-2:3]};
            status_out <= {|sum[2:0], 2'b00, ~|exp_r[EW-1:0]};
          end
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq: default 6/25 format plus an 8/23 instance.
module tb_fp_addsub_seq;

  logic        clock_100kHz = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] op_A_in, op_B_in, data_out;
  logic [3:0]  status_out;
  logic [2:0]  qual_lugar;

  logic        in_valid8, in_ready8, op_sub8, out_valid8, out_ready8;
  logic [31:0] op_A_in8, op_B_in8, data_out8;
  logic [3:0]  status_out8;
  logic [2:0]  qual_lugar8;

  int checks   = 0;
  int failures = 0;

  always #5 clock_100kHz = ~clock_100kHz;

  fp_addsub_seq dut (
    .clock_100kHz(clock_100kHz), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_A_in(op_A_in), .op_B_in(op_B_in), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out), .qual_lugar(qual_lugar)
  );

  fp_addsub_seq #(.EW(8), .MW(23)) dut8 (
    .clock_100kHz(clock_100kHz), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .op_A_in(op_A_in8), .op_B_in(op_B_in8), .op_sub(op_sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .data_out(data_out8), .status_out(status_out8), .qual_lugar(qual_lugar8)
  );

  // Presents one operation, scrambles the inputs after acceptance and returns the
  // number of edges until out_valid (-1 if it never rises; the DUT is then reset).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output int lat);
    @(negedge clock_100kHz);
    op_A_in = a; op_B_in = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clock_100kHz); #1;
    in_valid = 1'b0; op_A_in = 32'hDEADBEEF; op_B_in = 32'h12345678; op_sub = ~sub;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock_100kHz); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      reset = 1'b1; #2; reset = 1'b0;
    end
  endtask

  task automatic accept_result();
    @(negedge clock_100kHz);
    out_ready = 1'b1;
    @(posedge clock_100kHz); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", data_out); end
    if (status_out !== 4'b0) begin failures++; $display("FAIL reset_status: got %b expected 0000", status_out); end
    if (qual_lugar !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", qual_lugar); end
    @(negedge clock_100kHz);
    reset = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    do_op(32'h3E000000, 32'h40000000, 1'b0, lat);
    checks += 5;
    if (lat !== 4) begin failures++; $display("FAIL add_latency: got %0d expected 4", lat); end
    if (data_out !== 32'h41000000) begin failures++; $display("FAIL add_data: got %h expected 41000000", data_out); end
    if (status_out !== 4'b0000) begin failures++; $display("FAIL add_status: got %b expected 0000", status_out); end
    accept_result();
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_release_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL add_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_sub_negative();
    int lat;
    do_op(32'h3E000000, 32'h40000000, 1'b1, lat); // 1.0 - 2.0
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL subneg_latency: got %0d expected 4", lat); end
    if (data_out !== 32'hBE000000) begin failures++; $display("FAIL subneg_data: got %h expected BE000000", data_out); end
    if (status_out !== 4'b0000) begin failures++; $display("FAIL subneg_status: got %b expected 0000", status_out); end
    accept_result();
  endtask

  task automatic test_cancel();
    int lat;
    do_op(32'h40000000, 32'h40000000, 1'b1, lat);
    checks += 3;
    if (lat !== 3) begin failures++; $display("FAIL cancel_latency: got %0d expected 3", lat); end
    if (data_out !== 32'h00000000) begin failures++; $display("FAIL cancel_data: got %h expected 00000000", data_out); end
    if (status_out !== 4'b0001) begin failures++; $display("FAIL cancel_status: got %b expected 0001", status_out); end
    accept_result();
  endtask

  task automatic test_zero_operand();
    int lat;
    do_op(32'h0155AAAA, 32'h3E000000, 1'b0, lat); // exponent field 0: mantissa ignored
    checks += 3;
    if (lat !== 3) begin failures++; $display("FAIL zeroop_latency: got %0d expected 3", lat); end
    if (data_out !== 32'h3E000000) begin failures++; $display("FAIL zeroop_data: got %h expected 3E000000", data_out); end
    if (status_out !== 4'b0000) begin failures++; $display("FAIL zeroop_status: got %b expected 0000", status_out); end
    accept_result();
    do_op(32'h80000000, 32'h00000000, 1'b0, lat);
    checks += 2;
    if (data_out !== 32'h00000000) begin failures++; $display("FAIL bothzero_data: got %h expected 00000000", data_out); end
    if (status_out !== 4'b0001) begin failures++; $display("FAIL bothzero_status: got %b expected 0001", status_out); end
    accept_result();
  endtask

  task automatic test_overflow();
    int lat;
    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, lat);
    checks += 3;
    if (lat !== 3) begin failures++; $display("FAIL ovf_latency: got %0d expected 3", lat); end
    if (data_out !== 32'h7FFFFFFF) begin failures++; $display("FAIL ovf_data: got %h expected 7FFFFFFF", data_out); end
    if (status_out !== 4'b1010) begin failures++; $display("FAIL ovf_status: got %b expected 1010", status_out); end
    accept_result();
  endtask

  task automatic test_underflow();
    int lat;
    do_op(32'h02000001, 32'h02000000, 1'b1, lat); // one ulp left, 25 normalize shifts
    checks += 3;
    if (lat !== 27) begin failures++; $display("FAIL unf_latency: got %0d expected 27", lat); end
    if (data_out !== 32'h00000000) begin failures++; $display("FAIL unf_data: got %h expected 00000000", data_out); end
    if (status_out !== 4'b0101) begin failures++; $display("FAIL unf_status: got %b expected 0101", status_out); end
    accept_result();
  endtask

  task automatic test_align_sticky();
    int lat;
    do_op(32'h3E000000, 32'h08000000, 1'b0, lat); // 1.0 + 2^-27
    checks += 3;
    if (lat !== 30) begin failures++; $display("FAIL sticky_latency: got %0d expected 30", lat); end
    if (data_out !== 32'h3E000000) begin failures++; $display("FAIL sticky_data: got %h expected 3E000000", data_out); end
    if (status_out !== 4'b1000) begin failures++; $display("FAIL sticky_status: got %b expected 1000", status_out); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'h3E000000, 32'h40000000, 1'b0, lat);
    checks += 1;
    if (lat !== 4) begin failures++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_100kHz);
      out_ready = 1'b0; in_valid = 1'b1; op_A_in = 32'h40000000; op_B_in = 32'h40000000; op_sub = 1'b1;
      @(posedge clock_100kHz); #1;
      checks += 5;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      if (data_out !== 32'h41000000) begin failures++; $display("FAIL bp_data[%0d]: got %h expected 41000000", i, data_out); end
      if (status_out !== 4'b0000) begin failures++; $display("FAIL bp_status[%0d]: got %b expected 0000", i, status_out); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      if (qual_lugar !== 3'd5) begin failures++; $display("FAIL bp_state[%0d]: got %0d expected 5", i, qual_lugar); end
    end
    @(negedge clock_100kHz);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock_100kHz); #1;
    out_ready = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    if (qual_lugar !== 3'd0) begin failures++; $display("FAIL bp_release_state: got %0d expected 0", qual_lugar); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    if (data_out !== 32'h41000000) begin failures++; $display("FAIL bp_retain_data: got %h expected 41000000", data_out); end
  endtask

  task automatic test_reset_mid_align();
    int lat;
    @(negedge clock_100kHz);
    op_A_in = 32'h3E000000; op_B_in = 32'h08000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clock_100kHz); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock_100kHz);
    #1;
    checks += 1;
    if (qual_lugar !== 3'd1) begin failures++; $display("FAIL midalign_state: got %0d expected 1", qual_lugar); end
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (qual_lugar !== 3'd0) begin failures++; $display("FAIL midreset_state: got %0d expected 0", qual_lugar); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    if (data_out !== 32'h0) begin failures++; $display("FAIL midreset_data: got %h expected 00000000", data_out); end
    if (status_out !== 4'b0) begin failures++; $display("FAIL midreset_status: got %b expected 0000", status_out); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
    @(negedge clock_100kHz);
    reset = 1'b0;
    do_op(32'h3E000000, 32'h40000000, 1'b0, lat);
    checks += 2;
    if (lat !== 4) begin failures++; $display("FAIL postreset_latency: got %0d expected 4", lat); end
    if (data_out !== 32'h41000000) begin failures++; $display("FAIL postreset_data: got %h expected 41000000", data_out); end
    accept_result();
  endtask

  task automatic test_param8();
    int lat;
    @(negedge clock_100kHz);
    op_A_in8 = 32'h3F800000; op_B_in8 = 32'h40000000; op_sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clock_100kHz); #1;
    in_valid8 = 1'b0; op_A_in8 = 32'hFFFFFFFF; op_B_in8 = 32'h0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clock_100kHz); #1;
      if (out_valid8) begin
        lat = i;
        break;
      end
    end
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL p8_latency: got %0d expected 4", lat); end
    if (data_out8 !== 32'h40400000) begin failures++; $display("FAIL p8_data: got %h expected 40400000", data_out8); end
    if (status_out8 !== 4'b0000) begin failures++; $display("FAIL p8_status: got %b expected 0000", status_out8); end
    @(negedge clock_100kHz);
    out_ready8 = 1'b1;
    @(posedge clock_100kHz); #1;
    out_ready8 = 1'b0;
    checks += 1;
    if (out_valid8 !== 1'b0) begin failures++; $display("FAIL p8_release: got %b expected 0", out_valid8); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; op_A_in = '0; op_B_in = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op_sub8 = 1'b0; op_A_in8 = '0; op_B_in8 = '0;
    #12;
    test_reset();
    test_add();
    test_sub_negative();
    test_cancel();
    test_zero_operand();
    test_overflow();
    test_underflow();
    test_align_sticky();
    test_backpressure();
    test_reset_mid_align();
    test_param8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
